// File: rtl/irq_cp0_ctrl.sv
// irq_cp0_ctrl: prioritised, nestable interrupt controller with CP0 interrupt registers.
// Latches NUM_IRQ request lines into a pending register and applies mask and global disable.
// Redirects the core to the highest-priority pending source that outranks the handler in service.
// Return PCs and previous levels live on an EPC stack that eret pops.
// Optional build macro IRQ_CP0_EDGE_DETECT_EN: pend on 0->1 transitions instead of levels.
module irq_cp0_ctrl #(
  parameter int unsigned NUM_IRQ    = 8,
  parameter int unsigned NEST_DEPTH = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0400,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_sign,
  input  logic [31:0]        pc_next,
  input  logic               eret,
  input  logic               cp0_we,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        cp0_wdata,
  output logic [31:0]        cp0_rdata,
  output logic               irq_take,
  output logic [31:0]        irq_vector,
  output logic [31:0]        epc_out
);

  localparam int unsigned LVL_W = $clog2(NUM_IRQ + 1);
  localparam int unsigned SP_W  = $clog2(NEST_DEPTH + 1);

  localparam logic [4:0] ADDR_EPC  = 5'h0e;
  localparam logic [4:0] ADDR_DIS  = 5'h16;
  localparam logic [4:0] ADDR_MASK = 5'h17;
  localparam logic [4:0] ADDR_PEND = 5'h18;
  localparam logic [4:0] ADDR_STAT = 5'h19;

  // Architectural state
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               dis_q, dis_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic [31:0]        epc_stk_q [NEST_DEPTH];
  logic [31:0]        epc_stk_d [NEST_DEPTH];
  logic [LVL_W-1:0]   lvl_stk_q [NEST_DEPTH];
  logic [LVL_W-1:0]   lvl_stk_d [NEST_DEPTH];

  // Decode and arbitration
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] cand_oh;
  logic [NUM_IRQ-1:0] pend_set;
  logic [NUM_IRQ-1:0] pend_clr;
  logic [LVL_W-1:0]   cand_lvl;
  logic [LVL_W-1:0]   eff_lvl;
  logic [SP_W-1:0]    eff_sp;
  logic [31:0]        cand_idx;
  logic [31:0]        top_epc;
  logic [LVL_W-1:0]   top_lvl;
  logic               pop;

`ifdef IRQ_CP0_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] irq_sign_q;

  // Previous sample of the request lines for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_sign_q <= '0;
    end else begin
      irq_sign_q <= irq_sign;
    end
  end

  assign pend_set = irq_sign & ~irq_sign_q;
`else
  assign pend_set = irq_sign;
`endif

  assign eligible = dis_q ? '0 : (pending_q & mask_q);

  // Highest-index eligible source wins; cand_lvl is its index + 1, 0 when none
  always_comb begin
    cand_lvl = '0;
    cand_oh  = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i]) begin
        cand_lvl   = LVL_W'(i + 1);
        cand_oh    = '0;
        cand_oh[i] = 1'b1;
      end
    end
  end

  // Top-of-stack read mux; stays zero while the stack is empty
  always_comb begin
    top_epc = '0;
    top_lvl = '0;
    for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) begin
        top_epc = epc_stk_q[i];
        top_lvl = lvl_stk_q[i];
      end
    end
  end

  // Take decision sees the state as it will be after a same-cycle eret pop
  always_comb begin
    pop        = eret && (sp_q != '0);
    eff_lvl    = pop ? top_lvl : level_q;
    eff_sp     = pop ? (sp_q - SP_W'(1)) : sp_q;
    irq_take   = (|eligible) && (cand_lvl > eff_lvl) && (eff_sp < SP_W'(NEST_DEPTH));
    cand_idx   = (cand_lvl == '0) ? 32'd0 : (32'(cand_lvl) - 32'd1);
    irq_vector = VEC_BASE + (cand_idx * VEC_STRIDE);
    epc_out    = top_epc;
  end

  // Next-state: pending latch, CP0 writes, stack pop/push
  always_comb begin
    pend_clr  = '0;
    mask_d    = mask_q;
    dis_d     = dis_q;
    epc_stk_d = epc_stk_q;
    lvl_stk_d = lvl_stk_q;

    if (cp0_we) begin
      unique case (cp0_addr)
        ADDR_PEND: pend_clr = cp0_wdata[NUM_IRQ-1:0];
        ADDR_MASK: mask_d   = cp0_wdata[NUM_IRQ-1:0];
        ADDR_DIS:  dis_d    = cp0_wdata[0];
        default:   ;
      endcase
    end
    if (irq_take) begin
      pend_clr = pend_clr | cand_oh;
    end
    // New requests win over any clear in the same cycle
    pending_d = (pending_q & ~pend_clr) | pend_set;

    // EPC write patches the current top; a same-cycle push into that slot overrides it
    for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
      if (cp0_we && (cp0_addr == ADDR_EPC) && (sp_q == SP_W'(i + 1))) begin
        epc_stk_d[i] = cp0_wdata;
      end
    end
    for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
      if (irq_take && (eff_sp == SP_W'(i))) begin
        epc_stk_d[i] = pc_next;
        lvl_stk_d[i] = eff_lvl;
      end
    end

    sp_d    = irq_take ? (eff_sp + SP_W'(1)) : eff_sp;
    level_d = irq_take ? cand_lvl : eff_lvl;
  end

  // mfc0 read mux
  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      ADDR_EPC:  cp0_rdata = top_epc;
      ADDR_DIS:  cp0_rdata = {31'd0, dis_q};
      ADDR_MASK: cp0_rdata = 32'(mask_q);
      ADDR_PEND: cp0_rdata = 32'(pending_q);
      ADDR_STAT: cp0_rdata = {16'd0, 8'(sp_q), 8'(level_q)};
      default:   cp0_rdata = '0;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      mask_q    <= '0;
      dis_q     <= 1'b0;
      level_q   <= '0;
      sp_q      <= '0;
      for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
        epc_stk_q[i] <= '0;
        lvl_stk_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      dis_q     <= dis_d;
      level_q   <= level_d;
      sp_q      <= sp_d;
      epc_stk_q <= epc_stk_d;
      lvl_stk_q <= lvl_stk_d;
    end
  end

endmodule

// File: tb/tb_irq_cp0_ctrl.sv
// Bench for irq_cp0_ctrl: directed scenarios followed by random traffic, every cycle
// compared against a queue-based model of the interrupt/EPC-stack rules.
module tb_irq_cp0_ctrl;

  localparam int          NIRQ  = 8;
  localparam int          DEPTH = 4;
  localparam logic [31:0] VBASE = 32'h0000_0400;
  localparam logic [31:0] VSTR  = 32'h0000_0100;
`ifdef IRQ_CP0_EDGE_DETECT_EN
  localparam int HOLD_TAKES = 1;
`else
  localparam int HOLD_TAKES = 2;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NIRQ-1:0] irq_sign;
  logic [31:0]     pc_next;
  logic            eret;
  logic            cp0_we;
  logic [4:0]      cp0_addr;
  logic [31:0]     cp0_wdata;
  logic [31:0]     cp0_rdata;
  logic            irq_take;
  logic [31:0]     irq_vector;
  logic [31:0]     epc_out;

  always #5 clk = ~clk;

  irq_cp0_ctrl #(
    .NUM_IRQ   (NIRQ),
    .NEST_DEPTH(DEPTH),
    .VEC_BASE  (VBASE),
    .VEC_STRIDE(VSTR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_sign  (irq_sign),
    .pc_next   (pc_next),
    .eret      (eret),
    .cp0_we    (cp0_we),
    .cp0_addr  (cp0_addr),
    .cp0_wdata (cp0_wdata),
    .cp0_rdata (cp0_rdata),
    .irq_take  (irq_take),
    .irq_vector(irq_vector),
    .epc_out   (epc_out)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int n_takes  = 0;

  // Reference model state
  logic [7:0]  m_pend = '0;
  logic [7:0]  m_mask = '0;
  logic [7:0]  m_prev = '0;
  logic        m_dis  = 1'b0;
  int          m_lvl  = 0;
  logic [31:0] q_pc[$];
  int          q_lvl[$];

  // Per-cycle model decisions, reused at the clock edge
  int e_cand;
  int e_eff;
  bit e_pop;
  bit e_take;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] s, input logic e, input logic we, input logic [4:0] a,
                       input logic [31:0] wd, input logic [31:0] pc);
    irq_sign  = s;
    eret      = e;
    cp0_we    = we;
    cp0_addr  = a;
    cp0_wdata = wd;
    pc_next   = pc;
  endtask

  // Wait to mid-cycle, compute what the rules require, compare all outputs
  task automatic settle();
    logic [7:0]  elig;
    int          depth;
    logic [31:0] exp_vec, exp_epc, exp_rd;
    #4;
    elig   = m_dis ? 8'h00 : (m_pend & m_mask);
    e_cand = -1;
    for (int i = 0; i < NIRQ; i++) if (elig[i]) e_cand = i;
    e_pop  = eret && (q_pc.size() > 0);
    e_eff  = e_pop ? q_lvl[q_lvl.size() - 1] : m_lvl;
    depth  = q_pc.size() - (e_pop ? 1 : 0);
    e_take = (e_cand >= 0) && (e_cand + 1 > e_eff) && (depth < DEPTH);
    exp_vec = VBASE + VSTR * 32'((e_cand < 0) ? 0 : e_cand);
    exp_epc = (q_pc.size() > 0) ? q_pc[q_pc.size() - 1] : 32'h0;
    case (cp0_addr)
      5'h0e:   exp_rd = exp_epc;
      5'h16:   exp_rd = {31'd0, m_dis};
      5'h17:   exp_rd = {24'd0, m_mask};
      5'h18:   exp_rd = {24'd0, m_pend};
      5'h19:   exp_rd = {16'd0, 8'(q_pc.size()), 8'(m_lvl)};
      default: exp_rd = 32'h0;
    endcase
    chk("take", {31'd0, irq_take}, {31'd0, e_take});
    chk("vector", irq_vector, exp_vec);
    chk("epc_out", epc_out, exp_epc);
    chk("rdata", cp0_rdata, exp_rd);
    if (irq_take === 1'b1) n_takes++;
  endtask

  // Clock edge: advance the model with the inputs still applied
  task automatic clock();
    logic [7:0] clr, set;
    @(posedge clk);
    if (cp0_we && cp0_addr == 5'h0e && q_pc.size() > 0) q_pc[q_pc.size() - 1] = cp0_wdata;
    if (e_pop) begin
      void'(q_pc.pop_back());
      void'(q_lvl.pop_back());
    end
    if (e_take) begin
      q_pc.push_back(pc_next);
      q_lvl.push_back(e_eff);
    end
    m_lvl = e_take ? e_cand + 1 : e_eff;
    clr = (cp0_we && cp0_addr == 5'h18) ? cp0_wdata[7:0] : 8'h00;
    if (e_take) clr[e_cand] = 1'b1;
`ifdef IRQ_CP0_EDGE_DETECT_EN
    set = irq_sign & ~m_prev;
`else
    set = irq_sign;
`endif
    m_pend = (m_pend & ~clr) | set;
    if (cp0_we && cp0_addr == 5'h16) m_dis = cp0_wdata[0];
    if (cp0_we && cp0_addr == 5'h17) m_mask = cp0_wdata[7:0];
    m_prev = irq_sign;
    #1;
  endtask

  task automatic cyc(input logic [7:0] s, input logic e, input logic we, input logic [4:0] a,
                     input logic [31:0] wd, input logic [31:0] pc);
    drive(s, e, we, a, wd, pc);
    settle();
    clock();
  endtask

  initial begin
    int ch_list[4] = '{1, 3, 5, 6};
    logic [4:0]  ra;
    logic [31:0] rw;

    rst_n = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 5'h19, 32'h0, 32'h0);
    #22;
    rst_n = 1'b1;
    #1;
    chk("rst_take", {31'd0, irq_take}, 32'd0);
    chk("rst_vector", irq_vector, VBASE);
    chk("rst_epc", epc_out, 32'h0);
    chk("rst_status", cp0_rdata, 32'h0);
    @(posedge clk);
    #1;

    // Single take of channel 2
    cyc(8'h00, 1'b0, 1'b1, 5'h17, 32'hff, 32'h0);
    cyc(8'h04, 1'b0, 1'b0, 5'h19, 32'h0, 32'h0);
    drive(8'h00, 1'b0, 1'b0, 5'h19, 32'h0, 32'h1000);
    settle();
    chk("p1_take", {31'd0, irq_take}, 32'd1);
    chk("p1_vec", irq_vector, 32'h600);
    clock();
    drive(8'h00, 1'b0, 1'b0, 5'h19, 32'h0, 32'h0);
    settle();
    chk("p1_status", cp0_rdata, 32'h0000_0103);
    chk("p1_epc", epc_out, 32'h1000);
    clock();
    cyc(8'h00, 1'b1, 1'b0, 5'h0, 32'h0, 32'h0);

    // Two pending: channel 2 first, channel 0 after eret
    cyc(8'h05, 1'b0, 1'b0, 5'h18, 32'h0, 32'h0);
    drive(8'h00, 1'b0, 1'b0, 5'h18, 32'h0, 32'h2000);
    settle();
    chk("p2_take2", {31'd0, irq_take}, 32'd1);
    chk("p2_vec2", irq_vector, 32'h600);
    clock();
    drive(8'h00, 1'b0, 1'b0, 5'h18, 32'h0, 32'h0);
    settle();
    chk("p2_hold0", {31'd0, irq_take}, 32'd0);
    chk("p2_pend0", cp0_rdata, 32'h01);
    clock();
    drive(8'h00, 1'b1, 1'b0, 5'h19, 32'h0, 32'h2000);
    settle();
    chk("p2_eret_epc", epc_out, 32'h2000);
    chk("p2_take0", {31'd0, irq_take}, 32'd1);
    chk("p2_vec0", irq_vector, 32'h400);
    clock();
    cyc(8'h00, 1'b1, 1'b0, 5'h0, 32'h0, 32'h0);

    // Nesting: 1 then 6; channel 0 waits for the second eret
    cyc(8'h02, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
    drive(8'h00, 1'b0, 1'b0, 5'h0, 32'h0, 32'h3000);
    settle();
    chk("p3_vec1", irq_vector, 32'h500);
    clock();
    cyc(8'h40, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
    drive(8'h00, 1'b0, 1'b0, 5'h0, 32'h0, 32'h3100);
    settle();
    chk("p3_take6", {31'd0, irq_take}, 32'd1);
    chk("p3_vec6", irq_vector, 32'ha00);
    clock();
    drive(8'h00, 1'b0, 1'b0, 5'h19, 32'h0, 32'h0);
    settle();
    chk("p3_status", cp0_rdata, 32'h0000_0207);
    clock();
    cyc(8'h01, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
    drive(8'h00, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
    settle();
    chk("p3_no_take0", {31'd0, irq_take}, 32'd0);
    clock();
    cyc(8'h00, 1'b1, 1'b0, 5'h19, 32'h0, 32'h0);
    drive(8'h00, 1'b0, 1'b0, 5'h19, 32'h0, 32'h0);
    settle();
    chk("p3_lvl2", cp0_rdata, 32'h0000_0102);
    clock();
    drive(8'h00, 1'b1, 1'b0, 5'h0, 32'h0, 32'h3000);
    settle();
    chk("p3_take0", {31'd0, irq_take}, 32'd1);
    chk("p3_vec0", irq_vector, 32'h400);
    clock();
    cyc(8'h00, 1'b1, 1'b0, 5'h0, 32'h0, 32'h0);

    // Full stack blocks channel 7 until one eret
    foreach (ch_list[k]) begin
      cyc(8'(1 << ch_list[k]), 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
      cyc(8'h00, 1'b0, 1'b0, 5'h0, 32'h0, 32'h4000 + 32'(ch_list[k]));
    end
    cyc(8'h80, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
    drive(8'h00, 1'b0, 1'b0, 5'h19, 32'h0, 32'h0);
    settle();
    chk("p4_full_no_take", {31'd0, irq_take}, 32'd0);
    chk("p4_full_status", cp0_rdata, 32'h0000_0407);
    clock();
    drive(8'h00, 1'b1, 1'b0, 5'h0, 32'h0, 32'h4100);
    settle();
    chk("p4_take7", {31'd0, irq_take}, 32'd1);
    chk("p4_vec7", irq_vector, 32'hb00);
    clock();
    repeat (DEPTH) cyc(8'h00, 1'b1, 1'b0, 5'h0, 32'h0, 32'h0);

    // Global disable, then W1C before re-enable
    cyc(8'h10, 1'b0, 1'b1, 5'h16, 32'h1, 32'h0);
    drive(8'h00, 1'b0, 1'b0, 5'h16, 32'h0, 32'h0);
    settle();
    chk("p5_disabled", {31'd0, irq_take}, 32'd0);
    chk("p5_dis_rd", cp0_rdata, 32'h1);
    clock();
    drive(8'h00, 1'b0, 1'b1, 5'h16, 32'h0, 32'h0);
    settle();
    chk("p5_prewrite", {31'd0, irq_take}, 32'd0);
    clock();
    drive(8'h00, 1'b0, 1'b0, 5'h0, 32'h0, 32'h5000);
    settle();
    chk("p5_take4", {31'd0, irq_take}, 32'd1);
    chk("p5_vec4", irq_vector, 32'h800);
    clock();
    cyc(8'h00, 1'b1, 1'b0, 5'h0, 32'h0, 32'h0);
    cyc(8'h10, 1'b0, 1'b1, 5'h16, 32'h1, 32'h0);
    cyc(8'h00, 1'b0, 1'b1, 5'h18, 32'h10, 32'h0);
    cyc(8'h00, 1'b0, 1'b1, 5'h16, 32'h0, 32'h0);
    drive(8'h00, 1'b0, 1'b0, 5'h18, 32'h0, 32'h0);
    settle();
    chk("p5_w1c_no_take", {31'd0, irq_take}, 32'd0);
    chk("p5_w1c_pend", cp0_rdata, 32'h0);
    clock();

    // eret coincident with a take
    cyc(8'h02, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
    cyc(8'h00, 1'b0, 1'b0, 5'h0, 32'h0, 32'h5100);
    cyc(8'h08, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
    drive(8'h00, 1'b1, 1'b0, 5'h0, 32'h0, 32'h6000);
    settle();
    chk("p6_take3", {31'd0, irq_take}, 32'd1);
    chk("p6_vec3", irq_vector, 32'h700);
    clock();
    drive(8'h00, 1'b0, 1'b0, 5'h19, 32'h0, 32'h0);
    settle();
    chk("p6_status", cp0_rdata, 32'h0000_0104);
    chk("p6_epc", epc_out, 32'h6000);
    clock();
    cyc(8'h00, 1'b1, 1'b0, 5'h0, 32'h0, 32'h0);

    // Held line across an eret: one take with edge detect, two when level-sensitive
    n_takes = 0;
    repeat (4) cyc(8'h20, 1'b0, 1'b0, 5'h0, 32'h0, 32'h7000);
    cyc(8'h20, 1'b1, 1'b0, 5'h0, 32'h0, 32'h7100);
    repeat (2) cyc(8'h20, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
    chk("hold_takes", 32'(n_takes), 32'(HOLD_TAKES));
    cyc(8'h00, 1'b0, 1'b1, 5'h18, 32'hff, 32'h0);
    cyc(8'h00, 1'b1, 1'b0, 5'h0, 32'h0, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0:       ra = 5'h0e;
        1:       ra = 5'h16;
        2:       ra = 5'h17;
        3:       ra = 5'h18;
        4:       ra = 5'h19;
        default: ra = 5'($urandom);
      endcase
      rw = $urandom;
      if (ra == 5'h16) rw = {31'd0, ($urandom_range(0, 3) == 0)};
      cyc(8'($urandom & $urandom & $urandom), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 5) == 0), ra, rw, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
